// File: rtl/serial_word_receiver_pkg.sv
// Shared encodings for the serial word receiver: FSM states and line levels.
package serial_word_receiver_pkg;

    // FSM state encodings; 2'b11 is unused and falls back to IDLE.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RECV = 2'b01;
    localparam logic [1:0] ST_STOP = 2'b10;

    // Serial line levels.
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_word_receiver_shift_capture.sv
// Direction-selectable shift-in register: MSB-first shifts left, LSB-first
// shifts right, one bit per enabled edge.
module shift_capture #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             msb_first,
    input  logic             din,
    output logic [WIDTH-1:0] data
);

    // Shift the incoming bit in from the LSB end (MSB-first) or the MSB end (LSB-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (en) begin
            if (msb_first) begin
                data <= {data[WIDTH-2:0], din};
            end else begin
                data <= {din, data[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits, stop bit.
// Emits a one-cycle VALID on a good frame and a one-cycle ERR on a bad stop bit.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             ERR,
    output logic             BUSY
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             dir_lat;
    logic             shift_en;
    logic [WIDTH-1:0] capture;

    // A data bit is taken on every enabled edge spent in RECV.
    assign shift_en = ENB && (state == ST_RECV);

    shift_capture #(
        .WIDTH(WIDTH)
    ) u_shift_capture (
        .clk      (clk),
        .reset    (reset),
        .en       (shift_en),
        .msb_first(dir_lat),
        .din      (S_IN),
        .data     (capture)
    );

    // Frame FSM, bit counter, direction latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            dir_lat <= 1'b0;
            Q       <= '0;
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            VALID <= 1'b0;
            ERR   <= 1'b0;
            if (ENB) begin
                case (state)
                    ST_IDLE: begin
                        if (S_IN == START_BIT) begin
                            state   <= ST_RECV;
                            dir_lat <= DIR;
                            bit_cnt <= '0;
                            BUSY    <= 1'b1;
                        end
                    end
                    ST_RECV: begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (S_IN == STOP_BIT) begin
                            Q     <= capture;
                            VALID <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed, table-driven bench for serial_word_receiver (WIDTH=4).
module tb_serial_word_receiver;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic [WIDTH-1:0] Q;
    logic             VALID;
    logic             ERR;
    logic             BUSY;

    int n_checks = 0;
    int n_errors = 0;

    serial_word_receiver #(
        .WIDTH(WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ENB  (ENB),
        .DIR  (DIR),
        .S_IN (S_IN),
        .Q    (Q),
        .VALID(VALID),
        .ERR  (ERR),
        .BUSY (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             enb;
        logic             dir;
        logic             s_in;
        logic [WIDTH-1:0] q;
        logic             valid;
        logic             err;
        logic             busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic enb, input logic dir, input logic s_in,
                       input logic [WIDTH-1:0] q, input logic valid, input logic err,
                       input logic busy);
        vec_t v;
        v.rst = rst; v.enb = enb; v.dir = dir; v.s_in = s_in;
        v.q = q; v.valid = valid; v.err = err; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge act, sample 1 ns later.
    task automatic step(input logic rst, input logic enb, input logic dir, input logic s_in);
        @(negedge clk);
        reset = rst; ENB = enb; DIR = dir; S_IN = s_in;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [WIDTH-1:0] q,
                           input logic valid, input logic err, input logic busy);
        chk({tag, "_Q"}, idx, Q, q);
        chk({tag, "_VALID"}, idx, {3'b000, VALID}, {3'b000, valid});
        chk({tag, "_ERR"}, idx, {3'b000, ERR}, {3'b000, err});
        chk({tag, "_BUSY"}, idx, {3'b000, BUSY}, {3'b000, busy});
    endtask

    initial begin
        reset = 1'b1; ENB = 1'b0; DIR = 1'b0; S_IN = 1'b1;

        // Frame MSB-first: data 1,1,0,1 -> 1101
        add(0,1,1,0, 4'b0000,0,0,1);
        add(0,1,1,1, 4'b0000,0,0,1);
        add(0,1,1,1, 4'b0000,0,0,1);
        add(0,1,1,0, 4'b0000,0,0,1);
        add(0,1,1,1, 4'b0000,0,0,1);
        add(0,1,1,1, 4'b1101,1,0,0);
        add(0,1,1,1, 4'b1101,0,0,0);
        // Framing error: stop bit 0, Q holds
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,0,0,1);
        add(0,1,1,0, 4'b1101,0,1,0);
        add(0,1,1,1, 4'b1101,0,0,0);
        // LSB-first 1,0,1,1 -> 1101, DIR toggled mid-frame
        add(0,1,0,0, 4'b1101,0,0,1);
        add(0,1,0,1, 4'b1101,0,0,1);
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,0,0,1);
        add(0,1,0,1, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,1,0,0);
        add(0,1,1,1, 4'b1101,0,0,0);
        // ENB stall for 3 edges after the 2nd data bit
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,0,0,1);
        add(0,0,1,0, 4'b1101,0,0,1);
        add(0,0,1,0, 4'b1101,0,0,1);
        add(0,0,1,0, 4'b1101,0,0,1);
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,1,0,0);
        add(0,0,1,1, 4'b1101,0,0,0);
        // Reset after 2nd data bit, then frame 0,1,1,0 -> 0110
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,0, 4'b1101,0,0,1);
        add(0,1,1,1, 4'b1101,0,0,1);
        add(1,1,1,1, 4'b0000,0,0,0);
        add(0,1,1,1, 4'b0000,0,0,0);
        add(0,1,1,0, 4'b0000,0,0,1);
        add(0,1,1,0, 4'b0000,0,0,1);
        add(0,1,1,1, 4'b0000,0,0,1);
        add(0,1,1,1, 4'b0000,0,0,1);
        add(0,1,1,0, 4'b0000,0,0,1);
        add(0,1,1,1, 4'b0110,1,0,0);
        // Back-to-back frames 1000 then 0011 with no idle bit
        add(0,1,1,0, 4'b0110,0,0,1);
        add(0,1,1,1, 4'b0110,0,0,1);
        add(0,1,1,0, 4'b0110,0,0,1);
        add(0,1,1,0, 4'b0110,0,0,1);
        add(0,1,1,0, 4'b0110,0,0,1);
        add(0,1,1,1, 4'b1000,1,0,0);
        add(0,1,1,0, 4'b1000,0,0,1);
        add(0,1,1,0, 4'b1000,0,0,1);
        add(0,1,1,0, 4'b1000,0,0,1);
        add(0,1,1,1, 4'b1000,0,0,1);
        add(0,1,1,1, 4'b1000,0,0,1);
        add(0,1,1,1, 4'b0011,1,0,0);
        add(0,1,1,1, 4'b0011,0,0,0);

        // Reset state
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk_all("reset", -1, 4'b0000, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].enb, vecs[i].dir, vecs[i].s_in);
            chk_all("vec", i, vecs[i].q, vecs[i].valid, vecs[i].err, vecs[i].busy);
        end

        // A held-low line with ENB=0 must not start a frame
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0);
            chk_all("gated_idle", k, 4'b0011, 1'b0, 1'b0, 1'b0);
        end

        // Minimum-latency frame MSB-first 1,0,1,0 -> 1010 after WIDTH+2 edges
        step(0, 1, 1, 0);
        chk_all("lat_start", 0, 4'b0011, 1'b0, 1'b0, 1'b1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        chk_all("lat_last", 0, 4'b0011, 1'b0, 1'b0, 1'b1);
        step(0, 1, 1, 1);
        chk_all("lat_stop", 0, 4'b1010, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
